backprop_collector: RTL and testbench

- Consumes the per-input weighted-error vectors that a layer of learning neurons drives on their backprop-change outputs.
- Sums the vectors across all downstream neurons, one 64-bit accumulator per input index.
- Streams the 64-bit totals, one per cycle, as the backprop words consumed by the upstream layer.
- Sits between two neuron layers. Closes the training loop from the backprop-change side back into the backprop input side.

---
 rtl/backprop_collector_if.sv | 29 ++
 rtl/backprop_collector.sv | 80 ++++++++
 tb/tb_backprop_collector.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/backprop_collector_if.sv
// Handshake bundle between downstream change producers, the collector and the
// upstream backprop consumer.
interface backprop_collector_if #(
  parameter int FANIN      = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int IW = (FANIN > 1) ? $clog2(FANIN) : 1;

  logic [FANIN-1:0][DATA_WIDTH-1:0] bc_change;
  logic                             bc_change_valid;
  logic                             bc_change_ready;
  logic [63:0]                      bc_backprop;
  logic [IW-1:0]                    bc_backprop_index;
  logic                             bc_backprop_valid;
  logic                             bc_backprop_ready;
  logic                             bc_frame_done;

  modport master (
    output bc_change, bc_change_valid, bc_backprop_ready,
    input  bc_change_ready, bc_backprop, bc_backprop_index,
    input  bc_backprop_valid, bc_frame_done
  );

  modport slave (
    input  bc_change, bc_change_valid, bc_backprop_ready,
    output bc_change_ready, bc_backprop, bc_backprop_index,
    output bc_backprop_valid, bc_frame_done
  );
endinterface

// File: rtl/backprop_collector.sv
// Sums NUM_NEURONS signed change vectors per input index into 64-bit totals,
// then streams the FANIN totals upstream one word per handshake.
module backprop_collector #(
  parameter int NUM_NEURONS = 4,
  parameter int FANIN       = 32,
  parameter int DATA_WIDTH  = 32
) (
  input logic                  bc_clock,
  input logic                  bc_reset,
  backprop_collector_if.slave  bus
);
  localparam int CW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int IW = (FANIN > 1) ? $clog2(FANIN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_NEURONS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FANIN - 1);

  typedef enum logic {COLLECT, EMIT} state_e;

  state_e        state_q;
  logic [63:0]   acc_q [FANIN];
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic          frame_done_q;

  function automatic logic [63:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(64-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  always_ff @(posedge bc_clock) begin
    frame_done_q <= 1'b0;
    if (bc_reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int unsigned i = 0; i < FANIN; i++) acc_q[i] <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.bc_change_valid) begin
            for (int unsigned i = 0; i < FANIN; i++)
              acc_q[i] <= acc_q[i] + sext(bus.bc_change[i]);
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= EMIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        EMIT: begin
          // Producer input is ignored here; it must hold its vector until COLLECT.
          if (bus.bc_backprop_ready) begin
            if (idx_q == IDX_LAST) begin
              for (int unsigned i = 0; i < FANIN; i++) acc_q[i] <= '0;
              idx_q        <= '0;
              state_q      <= COLLECT;
              frame_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  always_comb begin
    bus.bc_change_ready   = (state_q == COLLECT);
    bus.bc_backprop_valid = (state_q == EMIT);
    bus.bc_backprop       = '0;
    bus.bc_backprop_index = '0;
    if (state_q == EMIT) begin
      bus.bc_backprop       = acc_q[idx_q];
      bus.bc_backprop_index = idx_q;
    end
    bus.bc_frame_done = frame_done_q;
  end
endmodule

// File: tb/tb_backprop_collector.sv
// Directed bench for backprop_collector with a queue of expected backprop words.
module tb_backprop_collector;
  localparam int NN = 4;
  localparam int FI = 32;
  localparam int DW = 32;

  typedef logic [FI-1:0][DW-1:0] vec_t;
  typedef struct {
    logic [63:0] idx;
    logic [63:0] data;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     checks = 0;
  int     errors = 0;
  exp_t   sb[$];
  longint model [FI];
  int     nvec = 0;

  backprop_collector_if #(.FANIN(FI), .DATA_WIDTH(DW)) bus ();

  backprop_collector #(.NUM_NEURONS(NN), .FANIN(FI), .DATA_WIDTH(DW)) dut (
    .bc_clock (clk),
    .bc_reset (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input vec_t v);
    bus.bc_change       = v;
    bus.bc_change_valid = 1'b1;
    check("change_ready", 64'(bus.bc_change_ready), 64'd1);
    check("valid_in_collect", 64'(bus.bc_backprop_valid), 64'd0);
    tick();
    bus.bc_change_valid = 1'b0;
    for (int i = 0; i < FI; i++) model[i] += longint'($signed(v[i]));
    nvec++;
    if (nvec == NN) begin
      for (int i = 0; i < FI; i++) begin
        sb.push_back('{idx: 64'(i), data: 64'(model[i])});
        model[i] = 0;
      end
      nvec = 0;
    end
  endtask

  task automatic drain(input bit bp, input bit stall, input int max_words);
    int       cycles = 0;
    int       taken  = 0;
    bit       take;
    bit [3:0] pat = 4'b1001;
    check("first_word_valid", 64'(bus.bc_backprop_valid), 64'd1);
    while (sb.size() > 0 && taken < max_words && cycles < 1000) begin
      check("emit_valid", 64'(bus.bc_backprop_valid), 64'd1);
      check("emit_index", 64'(bus.bc_backprop_index), sb[0].idx);
      check("emit_data", bus.bc_backprop, sb[0].data);
      check("emit_frame_done_low", 64'(bus.bc_frame_done), 64'd0);
      take = bp ? pat[cycles % 4] : 1'b1;
      bus.bc_backprop_ready = take;
      if (stall) begin
        bus.bc_change_valid = 1'b1;
        check("change_ready_in_emit", 64'(bus.bc_change_ready), 64'd0);
      end
      tick();
      cycles++;
      if (take) begin
        void'(sb.pop_front());
        taken++;
      end
    end
    bus.bc_backprop_ready = 1'b0;
    bus.bc_change_valid   = 1'b0;
    if (sb.size() != 0 && taken < max_words)
      check("drain_timeout", 64'(sb.size()), 64'd0);
    if (sb.size() == 0) begin
      check("frame_done_pulse", 64'(bus.bc_frame_done), 64'd1);
      check("ready_with_done", 64'(bus.bc_change_ready), 64'd1);
      check("valid_after_frame", 64'(bus.bc_backprop_valid), 64'd0);
      if (!bp) check("frame_cycles", 64'(cycles), 64'(FI));
      tick();
      check("frame_done_single", 64'(bus.bc_frame_done), 64'd0);
    end
  endtask

  initial begin
    vec_t v;
    bus.bc_change         = '0;
    bus.bc_change_valid   = 1'b0;
    bus.bc_backprop_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_change_ready", 64'(bus.bc_change_ready), 64'd1);
    check("rst_valid", 64'(bus.bc_backprop_valid), 64'd0);
    check("rst_data", bus.bc_backprop, 64'd0);
    check("rst_index", 64'(bus.bc_backprop_index), 64'd0);
    check("rst_frame_done", 64'(bus.bc_frame_done), 64'd0);

    repeat (10) begin
      tick();
      check("idle_change_ready", 64'(bus.bc_change_ready), 64'd1);
      check("idle_valid", 64'(bus.bc_backprop_valid), 64'd0);
      check("idle_frame_done", 64'(bus.bc_frame_done), 64'd0);
    end

    // Ramp frame: word i = 4*(i+1).
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < FI; i++) v[i] = 32'(i + 1);
      send_vec(v);
    end
    drain(1'b0, 1'b0, FI);

    // Signed mix including the most-negative entry.
    for (int n = 0; n < NN; n++) begin
      v    = '0;
      v[0] = 32'hFFFF_FFFF;
      v[1] = (n < 2) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      v[5] = 32'(n * 1000 - 1500);
      send_vec(v);
    end
    check("signed_word0", bus.bc_backprop, 64'hFFFF_FFFF_FFFF_FFFC);
    drain(1'b0, 1'b0, FI);

    // Backpressure with the producer pushing during EMIT.
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < FI; i++) v[i] = 32'(i * 7 - 100 + n * 13);
      send_vec(v);
    end
    drain(1'b1, 1'b1, FI);

    // Reset in the middle of emitting.
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < FI; i++) v[i] = 32'(i + 1);
      send_vec(v);
    end
    drain(1'b0, 1'b0, 10);
    check("pre_reset_index", 64'(bus.bc_backprop_index), 64'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("midrst_valid", 64'(bus.bc_backprop_valid), 64'd0);
    check("midrst_change_ready", 64'(bus.bc_change_ready), 64'd1);
    check("midrst_index", 64'(bus.bc_backprop_index), 64'd0);
    check("midrst_frame_done", 64'(bus.bc_frame_done), 64'd0);

    // All-ones then all-twos frames: words 4 then 8.
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < FI; i++) v[i] = 32'd1;
      send_vec(v);
    end
    check("ones_word0", bus.bc_backprop, 64'd4);
    drain(1'b0, 1'b0, FI);
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < FI; i++) v[i] = 32'd2;
      send_vec(v);
    end
    check("twos_word0", bus.bc_backprop, 64'd8);
    drain(1'b0, 1'b0, FI);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
